pixel_array_readout: RTL and testbench

- Parametrised digital back-end for an ROWS x COLS pixel array using a single-slope ADC.
- On START, enables the analog ramp and runs a shared Gray-code counter. Each pixel's comparator edge latches the counter value for that pixel.
- The frame is then read out row-serially over a valid/ready interface, as raw Gray or decoded binary.
- Sits between the analog pixel sensors (comparator outputs) and the frame buffer/readout logic.

---
 rtl/pixel_array_readout.sv | 131 +++++++++++++
 tb/tb_pixel_array_readout.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pixel_array_readout.sv
// Single-slope ADC back-end for a ROWS x COLS pixel array: a shared Gray counter is
// latched per pixel on its comparator edge, then the frame is streamed out row by row.
module pixel_array_readout #(
    parameter int ROWS     = 2,
    parameter int COLS     = 2,
    parameter int ADC_BITS = 8
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic                                  START,
    input  logic                                  DECODE,
    input  logic [ROWS*COLS-1:0]                  CMP,
    output logic                                  RAMP_EN,
    output logic                                  BUSY,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] ROW_SEL,
    output logic                                  DATA_VALID,
    input  logic                                  DATA_READY,
    output logic [COLS*ADC_BITS-1:0]              DATA_OUT,
    output logic                                  FRAME_DONE
);

    localparam int NPIX = ROWS * COLS;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ADC_BITS-1:0] CNT_MAX  = '1;
    localparam logic [RW-1:0]       LAST_ROW = RW'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, READOUT} state_t;

    state_t                state;
    logic [ADC_BITS-1:0]   cnt;
    logic [ADC_BITS-1:0]   gray;
    logic                  decode_q;
    logic [ADC_BITS-1:0]   codes [NPIX];
    logic [NPIX-1:0]       latched;
    logic [COLS*ADC_BITS-1:0] row_word [ROWS];

    function automatic logic [ADC_BITS-1:0] gray2bin(input logic [ADC_BITS-1:0] g);
        logic [ADC_BITS-1:0] b;
        b = g;
        for (int i = ADC_BITS - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign gray = cnt ^ (cnt >> 1);

    // Conversion, per-pixel capture and row handshake all live in one registered FSM;
    // a pixel that never trips its comparator is forced to the full-scale code on the last count.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            decode_q   <= 1'b0;
            latched    <= '0;
            RAMP_EN    <= 1'b0;
            BUSY       <= 1'b0;
            DATA_VALID <= 1'b0;
            FRAME_DONE <= 1'b0;
            ROW_SEL    <= '0;
            for (int p = 0; p < NPIX; p++) begin
                codes[p] <= '0;
            end
        end else begin
            FRAME_DONE <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (START) begin
                        state    <= CONVERT;
                        cnt      <= '0;
                        latched  <= '0;
                        decode_q <= DECODE;
                        RAMP_EN  <= 1'b1;
                        BUSY     <= 1'b1;
                    end
                end
                CONVERT: begin
                    for (int p = 0; p < NPIX; p++) begin
                        if (!latched[p] && (!CMP[p] || cnt == CNT_MAX)) begin
                            codes[p]   <= gray;
                            latched[p] <= 1'b1;
                        end
                    end
                    if (cnt == CNT_MAX) begin
                        cnt        <= '0;
                        state      <= READOUT;
                        RAMP_EN    <= 1'b0;
                        DATA_VALID <= 1'b1;
                        ROW_SEL    <= '0;
                    end else begin
                        cnt <= cnt + ADC_BITS'(1);
                    end
                end
                READOUT: begin
                    if (DATA_VALID && DATA_READY) begin
                        if (ROW_SEL == LAST_ROW) begin
                            state      <= IDLE;
                            DATA_VALID <= 1'b0;
                            FRAME_DONE <= 1'b1;
                            BUSY       <= 1'b0;
                            ROW_SEL    <= '0;
                        end else begin
                            ROW_SEL <= ROW_SEL + RW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            assign row_word[r][c*ADC_BITS +: ADC_BITS] =
                decode_q ? gray2bin(codes[r*COLS+c]) : codes[r*COLS+c];
        end
    end

    // Row mux is forced to zero outside a valid beat so stale codes never leak downstream.
    always_comb begin
        DATA_OUT = '0;
        if (DATA_VALID) begin
            for (int r = 0; r < ROWS; r++) begin
                if (ROW_SEL == RW'(r)) begin
                    DATA_OUT = row_word[r];
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_array_readout.sv
// Bench for pixel_array_readout: a 2x2/8-bit instance driven from a vector table with a
// row scoreboard, plus a 3x1/4-bit instance and a mid-conversion reset sequence.
module tb_pixel_array_readout;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, decode, data_ready;
    logic [3:0]  cmp;
    logic        ramp_en, busy, data_valid, frame_done;
    logic [0:0]  row_sel;
    logic [15:0] data_out;

    logic        s_start, s_decode, s_ready;
    logic [2:0]  s_cmp;
    logic        s_ramp_en, s_busy, s_valid, s_done;
    logic [1:0]  s_row_sel;
    logic [3:0]  s_data_out;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        dec;
        logic [8:0]  f0, f1, f2, f3;
        logic [3:0]  stall;
        logic        poke;
        logic [15:0] row0, row1;
    } vec_t;

    typedef struct packed {
        logic [31:0] row;
        logic [15:0] data;
    } exp_t;

    vec_t vecs [5];
    exp_t exp_q [$];

    always #5 clk = ~clk;

    pixel_array_readout #(.ROWS(2), .COLS(2), .ADC_BITS(8)) dut (
        .CLK(clk), .RESET(reset), .START(start), .DECODE(decode), .CMP(cmp),
        .RAMP_EN(ramp_en), .BUSY(busy), .ROW_SEL(row_sel), .DATA_VALID(data_valid),
        .DATA_READY(data_ready), .DATA_OUT(data_out), .FRAME_DONE(frame_done)
    );

    pixel_array_readout #(.ROWS(3), .COLS(1), .ADC_BITS(4)) dut_s (
        .CLK(clk), .RESET(reset), .START(s_start), .DECODE(s_decode), .CMP(s_cmp),
        .RAMP_EN(s_ramp_en), .BUSY(s_busy), .ROW_SEL(s_row_sel), .DATA_VALID(s_valid),
        .DATA_READY(s_ready), .DATA_OUT(s_data_out), .FRAME_DONE(s_done)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic cmpLevel(input int k, input logic [8:0] fall);
        // Comparator pulses low for three counts; the re-rise must not disturb the latch.
        return !(k >= int'(fall) && k < int'(fall) + 3);
    endfunction

    // Runs one frame on the 2x2 instance; START is raised in the current cycle,
    // which is the FRAME_DONE cycle of the previous frame when called back to back.
    task automatic applyStimulus(input vec_t v);
        int   t = 0;
        int   ramp_cnt = 0;
        int   stalls = 0;
        logic done = 1'b0;
        exp_t e;
        exp_q.push_back('{row: 0, data: v.row0});
        exp_q.push_back('{row: 1, data: v.row1});
        start      = 1'b1;
        decode     = v.dec;
        data_ready = 1'b1;
        while (!done && t < 600) begin
            @(negedge clk);
            t++;
            start      = v.poke && (t == 50 || t == 257);
            data_ready = 1'b1;
            cmp[0] = cmpLevel(t - 1, v.f0);
            cmp[1] = cmpLevel(t - 1, v.f1);
            cmp[2] = cmpLevel(t - 1, v.f2);
            cmp[3] = cmpLevel(t - 1, v.f3);
            if (t == 1) checkOutput("ramp_first_cycle", {31'd0, ramp_en}, 32'd1);
            if (t == 1) checkOutput("busy_convert", {31'd0, busy}, 32'd1);
            if (ramp_en) ramp_cnt++;
            if (frame_done) begin
                done = 1'b1;
                checkOutput("frame_latency", t, 259 + int'(v.stall));
                checkOutput("ramp_cycles", ramp_cnt, 256);
                checkOutput("done_busy", {31'd0, busy}, 32'd0);
                checkOutput("done_valid", {31'd0, data_valid}, 32'd0);
                checkOutput("done_data", {16'd0, data_out}, 32'd0);
                checkOutput("rows_left", exp_q.size(), 0);
            end else if (data_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_row", {16'd0, data_out}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q[0];
                    checkOutput("row_sel", {31'd0, row_sel}, e.row);
                    checkOutput("row_data", {16'd0, data_out}, {16'd0, e.data});
                    if (e.row == 0 && stalls < int'(v.stall)) begin
                        data_ready = 1'b0;
                        stalls++;
                    end else begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
        if (!done) checkOutput("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic runSmall(input logic dec, input logic [3:0] expv);
        int   t = 0;
        int   ramp_cnt = 0;
        int   row = 0;
        logic done = 1'b0;
        s_start  = 1'b1;
        s_decode = dec;
        s_ready  = 1'b1;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
            s_start = 1'b0;
            s_cmp   = (t - 1 >= 15) ? 3'b000 : 3'b111;
            if (s_ramp_en) ramp_cnt++;
            if (s_done) begin
                done = 1'b1;
                checkOutput("small_latency", t, 20);
                checkOutput("small_ramp", ramp_cnt, 16);
                checkOutput("small_rows", row, 3);
            end else if (s_valid) begin
                checkOutput("small_row_sel", {30'd0, s_row_sel}, row);
                checkOutput("small_data", {28'd0, s_data_out}, {28'd0, expv});
                row++;
            end
        end
        if (!done) checkOutput("small_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int extra;
        vecs[0] = '{dec: 1'b0, f0: 9'd5,   f1: 9'd0, f2: 9'd300, f3: 9'd200, stall: 4'd0, poke: 1'b0, row0: 16'h0007, row1: 16'hAC80};
        vecs[1] = '{dec: 1'b1, f0: 9'd5,   f1: 9'd0, f2: 9'd300, f3: 9'd200, stall: 4'd0, poke: 1'b0, row0: 16'h0005, row1: 16'hC8FF};
        vecs[2] = '{dec: 1'b0, f0: 9'd255, f1: 9'd1, f2: 9'd128, f3: 9'd64,  stall: 4'd0, poke: 1'b1, row0: 16'h0180, row1: 16'h60C0};
        vecs[3] = '{dec: 1'b1, f0: 9'd255, f1: 9'd1, f2: 9'd128, f3: 9'd64,  stall: 4'd0, poke: 1'b0, row0: 16'h01FF, row1: 16'h4080};
        vecs[4] = '{dec: 1'b0, f0: 9'd10,  f1: 9'd20, f2: 9'd30, f3: 9'd40,  stall: 4'd3, poke: 1'b1, row0: 16'h1E0F, row1: 16'h3C11};

        reset = 1'b1; start = 1'b0; decode = 1'b0; data_ready = 1'b0; cmp = 4'hF;
        s_start = 1'b0; s_decode = 1'b0; s_ready = 1'b0; s_cmp = 3'h7;
        repeat (3) @(negedge clk);
        checkOutput("reset_ramp", {31'd0, ramp_en}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_valid", {31'd0, data_valid}, 32'd0);
        checkOutput("reset_outputs", {13'd0, frame_done, row_sel, data_out}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
        end
        start = 1'b0;

        // Reset lands while the counter reads 100; the partial frame must vanish without a FRAME_DONE.
        start = 1'b1; decode = 1'b0; cmp = 4'hF;
        for (int t = 1; t <= 101; t++) begin
            @(negedge clk);
            start = 1'b0;
            cmp   = (t - 1 >= 20) ? 4'h0 : 4'hF;
        end
        reset = 1'b1;
        #1;
        checkOutput("midreset_ramp", {31'd0, ramp_en}, 32'd0);
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset_rest", {14'd0, data_valid, frame_done, row_sel, data_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cmp   = 4'hF;
        extra = 0;
        repeat (300) begin
            @(negedge clk);
            if (frame_done || busy) extra++;
        end
        checkOutput("no_done_after_reset", extra, 0);

        applyStimulus(vecs[0]);
        start = 1'b0;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (frame_done || data_valid) extra++;
        end
        checkOutput("idle_after_frame", extra, 0);

        runSmall(1'b0, 4'h8);
        runSmall(1'b1, 4'hF);
        s_start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
